mem_arb2: RTL and testbench
===========================

MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter: RR_EN, default 1, selects arbitration policy: 1 = round-robin, 0 = fixed priority with master 0 winning.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_req_valid / m1_req_valid  input  1 each  master request valid.
REQ-005 m0_req_ready / m1_req_ready  output  1 each  master request accepted.
REQ-006 m0_req / m1_req  input  mem_req_t  master request; fields req_addr, req_data, req_mask, req_type.
REQ-007 m0_resp_valid / m1_resp_valid  output  1 each  response valid to master.
REQ-008 m0_resp_ready / m1_resp_ready  input  1 each  master response ready.
REQ-009 m0_resp / m1_resp  output  mem_resp_t  response to master; fields resp_data, resp_last.
REQ-010 s_req_valid  output  1, s_req_ready  input  1, s_req  output  mem_req_t  slave request port (e.g. clint).
REQ-011 s_resp_valid  input  1, s_resp_ready  output  1, s_resp  input  mem_resp_t  slave response port.
REQ-012 grant_id  output  1  index of the currently owning master; valid only outside IDLE.

Function
REQ-013 FSM states: IDLE, REQ, RESP; one transaction outstanding at most.
REQ-014 IDLE: if either m*_req_valid=1, register winner into grant_id and go to REQ next cycle; no ready asserted in IDLE.
REQ-015 Arbitration, both valid, RR_EN=1: grant the master not granted last (last_grant register); RR_EN=0: grant m0.
REQ-016 Arbitration, single valid: grant that master regardless of RR_EN or last_grant.
REQ-017 REQ: s_req_valid = m[grant_id]_req_valid; s_req = m[grant_id]_req; m[grant_id]_req_ready = s_req_ready; other master's ready = 0.
REQ-018 REQ -> RESP on s_req_valid && s_req_ready; last_grant <= grant_id on the same edge.
REQ-019 REQ -> IDLE if the granted master drops req_valid before the handshake; no slave transaction issued; last_grant unchanged.
REQ-020 RESP: m[grant_id]_resp_valid = s_resp_valid; m[grant_id]_resp = s_resp; s_resp_ready = m[grant_id]_resp_ready; other master's resp_valid = 0.
REQ-021 RESP -> IDLE on s_resp_valid && s_resp_ready && s_resp.resp_last; beats without resp_last are forwarded and state remains RESP.
REQ-022 Non-granted master's resp fields SHALL be driven to zero.
REQ-023 s_req SHALL be zero whenever s_req_valid=0; s_resp_ready=0 outside RESP.
REQ-024 Minimum transaction latency: request seen in IDLE cycle N -> slave handshake earliest cycle N+1 -> response to master earliest cycle N+2 (for a one-cycle slave), back-to-back grant earliest cycle N+3.
REQ-025 New master requests arriving in REQ or RESP are held off (ready=0) until the FSM returns to IDLE; no request is dropped or duplicated.
REQ-026 Arbiter adds no combinational path from s_req_ready to s_req_valid.

Reset
REQ-027 On rstn=0, asynchronously: state=IDLE, grant_id=0, last_grant=1 (m0 wins first tie), all valid/ready outputs 0, all data outputs 0.
REQ-028 Reset asserted mid-transaction abandons it; after release the arbiter starts in IDLE with no pending response routed.

Verification
REQ-029 Single m0 write (addr 0x0C, data 0x0000_1234, mask 0xF): s_req carries identical fields one cycle after m0_req_valid; slave response routed only to m0; grant_id=0.
REQ-030 m0 and m1 valid continuously, RR_EN=1, 6 transactions: grant order 0,1,0,1,0,1; each master's responses match its own requests.
REQ-031 Same stimulus, RR_EN=0: all grants to m0 while m0_req_valid held; m1 granted only in the first IDLE with m0_req_valid=0.
REQ-032 Slave backpressure: s_req_ready=0 for 5 cycles then 1; m[grant]_req_ready mirrors it, exactly one s_req handshake; m0_resp_ready=0 for 3 cycles holds state RESP and s_resp_ready=0.
REQ-033 rstn pulsed low during RESP: all outputs 0 immediately; after release, m1-only request granted with grant_id=1 and completes normally.
REQ-034 Granted m1 drops req_valid in REQ before s_req_ready: FSM returns to IDLE, no slave handshake, next tie (m0 and m1 both valid) grants m1 (last_grant unchanged).

Source files
------------

// File: rtl/mem_arb2.sv
// rtl/mem_arb2.sv - two-master to one-slave memory request arbiter
// One transaction in flight; round-robin or fixed-priority grant, selected by RR_EN.
package mem_arb2_pkg;

  typedef struct packed {
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic        req_type;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_data;
    logic        resp_last;
  } mem_resp_t;

endpackage

module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rstn,

  input  logic      m0_req_valid,
  output logic      m0_req_ready,
  input  mem_req_t  m0_req,
  output logic      m0_resp_valid,
  input  logic      m0_resp_ready,
  output mem_resp_t m0_resp,

  input  logic      m1_req_valid,
  output logic      m1_req_ready,
  input  mem_req_t  m1_req,
  output logic      m1_resp_valid,
  input  logic      m1_resp_ready,
  output mem_resp_t m1_resp,

  output logic      s_req_valid,
  input  logic      s_req_ready,
  output mem_req_t  s_req,
  input  logic      s_resp_valid,
  output logic      s_resp_ready,
  input  mem_resp_t s_resp,

  output logic      grant_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       winner;
  logic       in_req;
  logic       in_resp;
  logic       gnt_valid;
  mem_req_t   gnt_req;
  logic       gnt_resp_ready;

  // A lone requester always wins; a tie goes to the master not served last.
  always_comb begin
    winner = m1_req_valid;
    if (m0_req_valid && m1_req_valid) begin
      winner = RR_EN ? ~last_grant : 1'b0;
    end
  end

  always_comb begin
    in_req         = (state == ST_REQ);
    in_resp        = (state == ST_RESP);
    gnt_valid      = grant_id ? m1_req_valid  : m0_req_valid;
    gnt_req        = grant_id ? m1_req        : m0_req;
    gnt_resp_ready = grant_id ? m1_resp_ready : m0_resp_ready;
  end

  // s_req_valid depends only on state and the granted master, never on s_req_ready.
  always_comb begin
    s_req_valid  = in_req && gnt_valid;
    s_req        = s_req_valid ? gnt_req : '0;
    m0_req_ready = in_req && !grant_id && s_req_ready;
    m1_req_ready = in_req &&  grant_id && s_req_ready;
  end

  always_comb begin
    s_resp_ready  = in_resp && gnt_resp_ready;
    m0_resp_valid = in_resp && !grant_id && s_resp_valid;
    m1_resp_valid = in_resp &&  grant_id && s_resp_valid;
    m0_resp       = (in_resp && !grant_id) ? s_resp : '0;
    m1_resp       = (in_resp &&  grant_id) ? s_resp : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req_valid || m1_req_valid) begin
            grant_id <= winner;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_req_valid && s_req_ready) begin
            state      <= ST_RESP;
            last_grant <= grant_id;
          end else if (!gnt_valid) begin
            // Requester withdrew before the slave took it: nothing was issued.
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (s_resp_valid && s_resp_ready && s_resp.resp_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// tb/tb_mem_arb2.sv - directed-vector bench for mem_arb2
// Instance a is round-robin, instance b fixed priority; both share master stimulus.
module tb_mem_arb2;
  import mem_arb2_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic m0_req_valid, m1_req_valid, m0_resp_ready, m1_resp_ready;
  mem_req_t m0_req, m1_req;
  logic s_rdy;
  logic [1:0] beats;

  logic m0_req_ready_a, m1_req_ready_a, m0_resp_valid_a, m1_resp_valid_a;
  mem_resp_t m0_resp_a, m1_resp_a, s_resp_a;
  logic s_req_valid_a, s_resp_valid_a, s_resp_ready_a, grant_id_a;
  mem_req_t s_req_a;

  logic m0_req_ready_b, m1_req_ready_b, m0_resp_valid_b, m1_resp_valid_b;
  mem_resp_t m0_resp_b, m1_resp_b, s_resp_b;
  logic s_req_valid_b, s_resp_valid_b, s_resp_ready_b, grant_id_b;
  mem_req_t s_req_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic ga[$];
  logic gb[$];
  int ta[$];
  logic rr_mon = 1'b0;
  int rc0, rc1, rb1, hs0, nb;
  mem_req_t exp_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb2 #(.RR_EN(1'b1)) dut_a (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready_a), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid_a), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp_a),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready_a), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid_a), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp_a),
    .s_req_valid(s_req_valid_a), .s_req_ready(s_rdy), .s_req(s_req_a),
    .s_resp_valid(s_resp_valid_a), .s_resp_ready(s_resp_ready_a), .s_resp(s_resp_a),
    .grant_id(grant_id_a)
  );

  mem_arb2 #(.RR_EN(1'b0)) dut_b (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready_b), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid_b), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp_b),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready_b), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid_b), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp_b),
    .s_req_valid(s_req_valid_b), .s_req_ready(s_rdy), .s_req(s_req_b),
    .s_resp_valid(s_resp_valid_b), .s_resp_ready(s_resp_ready_b), .s_resp(s_resp_b),
    .grant_id(grant_id_b)
  );

  // Slave models: respond the cycle after a handshake with req_data+1, later beats +0x100.
  logic pend_a, pend_b;
  logic [1:0] left_a, left_b;
  logic [31:0] rdata_a, rdata_b;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_a <= 1'b0; left_a <= 2'd0; rdata_a <= 32'd0;
    end else if (pend_a && s_resp_ready_a) begin
      if (left_a == 2'd1) pend_a <= 1'b0;
      left_a  <= left_a - 2'd1;
      rdata_a <= rdata_a + 32'h100;
    end else if (s_req_valid_a && s_rdy) begin
      pend_a <= 1'b1; left_a <= beats; rdata_a <= s_req_a.req_data + 32'd1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_b <= 1'b0; left_b <= 2'd0; rdata_b <= 32'd0;
    end else if (pend_b && s_resp_ready_b) begin
      if (left_b == 2'd1) pend_b <= 1'b0;
      left_b  <= left_b - 2'd1;
      rdata_b <= rdata_b + 32'h100;
    end else if (s_req_valid_b && s_rdy) begin
      pend_b <= 1'b1; left_b <= beats; rdata_b <= s_req_b.req_data + 32'd1;
    end
  end

  assign s_resp_valid_a = pend_a;
  assign s_resp_a = pend_a ? {rdata_a, left_a == 2'd1} : '0;
  assign s_resp_valid_b = pend_b;
  assign s_resp_b = pend_b ? {rdata_b, left_b == 2'd1} : '0;

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake / response monitor, sampled mid-low-phase.
  always begin
    @(negedge clk);
    #2;
    if (rstn) begin
      if (s_req_valid_a && s_rdy) begin ga.push_back(grant_id_a); ta.push_back(cyc); end
      if (s_req_valid_b && s_rdy) gb.push_back(grant_id_b);
      if (rr_mon) begin
        if (m0_resp_valid_a && m0_resp_ready) begin
          rc0++;
          expect_eq("rr_m0_resp", 128'(m0_resp_a), 128'({32'hA1, 1'b1}));
        end
        if (m1_resp_valid_a && m1_resp_ready) begin
          rc1++;
          expect_eq("rr_m1_resp", 128'(m1_resp_a), 128'({32'hB1, 1'b1}));
        end
        if (m1_resp_valid_b) rb1++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1; s_rdy = 1'b1; beats = 2'd1;
    m0_req = '0; m1_req = '0;
    repeat (2) @(negedge clk);
    #1;
    expect_eq("rst_s_req_valid", 128'(s_req_valid_a), 128'(0));
    expect_eq("rst_s_req", 128'(s_req_a), 128'(0));
    expect_eq("rst_m0_req_ready", 128'(m0_req_ready_a), 128'(0));
    expect_eq("rst_resp_valids", 128'({m0_resp_valid_a, m1_resp_valid_a}), 128'(0));
    expect_eq("rst_s_resp_ready", 128'(s_resp_ready_a), 128'(0));
    expect_eq("rst_grant_id", 128'(grant_id_a), 128'(0));

    // Single m0 write
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    m0_req = '{32'h0C, 32'h0000_1234, 4'hF, 1'b1}; m0_req_valid = 1'b1;
    #1;
    expect_eq("idle_no_ready", 128'(m0_req_ready_a), 128'(0));
    expect_eq("idle_no_s_req", 128'(s_req_valid_a), 128'(0));
    @(negedge clk); #1;
    exp_r = '{32'h0C, 32'h0000_1234, 4'hF, 1'b1};
    expect_eq("w_grant_id", 128'(grant_id_a), 128'(0));
    expect_eq("w_s_req_valid", 128'(s_req_valid_a), 128'(1));
    expect_eq("w_s_req", 128'(s_req_a), 128'(exp_r));
    expect_eq("w_readies", 128'({m0_req_ready_a, m1_req_ready_a}), 128'(2'b10));
    @(negedge clk); m0_req_valid = 1'b0; #1;
    expect_eq("w_m0_resp_valid", 128'(m0_resp_valid_a), 128'(1));
    expect_eq("w_m0_resp", 128'(m0_resp_a), 128'({32'h1235, 1'b1}));
    expect_eq("w_m1_resp_quiet", 128'({m1_resp_valid_a, m1_resp_a}), 128'(0));
    expect_eq("w_s_req_zero", 128'({s_req_valid_a, s_req_a}), 128'(0));
    @(negedge clk); #1;
    expect_eq("w_back_idle", 128'({m0_resp_valid_a, s_resp_ready_a}), 128'(0));

    // Both masters continuously valid
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    ga.delete(); gb.delete(); ta.delete(); rc0 = 0; rc1 = 0; rb1 = 0;
    m0_req = '{32'h100, 32'hA0, 4'hF, 1'b1}; m1_req = '{32'h200, 32'hB0, 4'h3, 1'b1};
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; rr_mon = 1'b1;
    for (int k = 0; k < 40 && ga.size() < 6; k++) begin
      @(negedge clk); #3;
    end
    expect_eq("rr_six_grants", 128'(ga.size() >= 6), 128'(1));
    @(negedge clk); #3;
    rr_mon = 1'b0;
    if (ga.size() >= 6) begin
      for (int i = 0; i < 6; i++) expect_eq($sformatf("rr_order_%0d", i), 128'(ga[i]), 128'(i % 2));
      for (int i = 0; i < 5; i++) expect_eq($sformatf("rr_gap_%0d", i), 128'(ta[i+1] - ta[i]), 128'(3));
    end
    expect_eq("rr_m0_resp_count", 128'(rc0), 128'(3));
    expect_eq("rr_m1_resp_count", 128'(rc1), 128'(3));
    expect_eq("fp_grant_count", 128'(gb.size()), 128'(ga.size()));
    foreach (gb[i]) expect_eq($sformatf("fp_grant_%0d", i), 128'(gb[i]), 128'(0));
    expect_eq("fp_no_m1_resp", 128'(rb1), 128'(0));
    nb = gb.size();
    m0_req_valid = 1'b0;
    for (int k = 0; k < 10 && gb.size() <= nb; k++) @(negedge clk);
    #3;
    expect_eq("fp_m1_granted", 128'(gb.size() > nb), 128'(1));
    if (gb.size() > nb) expect_eq("fp_m1_after_drop", 128'(gb[nb]), 128'(1));
    m1_req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Slave request and master response backpressure
    s_rdy = 1'b0; hs0 = ga.size();
    m0_req = '{32'h300, 32'h55, 4'h1, 1'b0}; m0_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      expect_eq("bp_s_req_valid", 128'(s_req_valid_a), 128'(1));
      expect_eq("bp_ready_low", 128'(m0_req_ready_a), 128'(0));
    end
    @(negedge clk); s_rdy = 1'b1; #1;
    expect_eq("bp_ready_mirror", 128'(m0_req_ready_a), 128'(1));
    @(negedge clk); m0_req_valid = 1'b0; m0_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_eq("bp_resp_held", 128'({m0_resp_valid_a, s_resp_ready_a}), 128'(2'b10));
      @(negedge clk);
    end
    m0_resp_ready = 1'b1; #1;
    expect_eq("bp_resp_ready", 128'(s_resp_ready_a), 128'(1));
    @(negedge clk); #1;
    expect_eq("bp_done", 128'(m0_resp_valid_a), 128'(0));
    expect_eq("bp_one_handshake", 128'(ga.size() - hs0), 128'(1));

    // Two-beat response to m1
    @(negedge clk);
    beats = 2'd2; m1_req = '{32'h400, 32'h77, 4'hF, 1'b1}; m1_req_valid = 1'b1;
    @(negedge clk); #1;
    expect_eq("mb_grant", 128'({grant_id_a, m1_req_ready_a}), 128'(2'b11));
    @(negedge clk); m1_req_valid = 1'b0; #1;
    expect_eq("mb_beat0", 128'({m1_resp_valid_a, m1_resp_a}), 128'({1'b1, 32'h78, 1'b0}));
    expect_eq("mb_m0_quiet", 128'({m0_resp_valid_a, m0_resp_a}), 128'(0));
    @(negedge clk); #1;
    expect_eq("mb_beat1", 128'({m1_resp_valid_a, m1_resp_a}), 128'({1'b1, 32'h178, 1'b1}));
    @(negedge clk); #1;
    expect_eq("mb_done", 128'({m1_resp_valid_a, s_resp_ready_a}), 128'(0));
    beats = 2'd1;

    // Reset during RESP
    @(negedge clk);
    m0_req = '{32'h500, 32'h66, 4'hF, 1'b0}; m0_req_valid = 1'b1; m0_resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); m0_req_valid = 1'b0; #1;
    expect_eq("rr_in_resp", 128'(m0_resp_valid_a), 128'(1));
    rstn = 1'b0; #1;
    expect_eq("arst_valids", 128'({m0_resp_valid_a, s_resp_ready_a, s_req_valid_a, grant_id_a}), 128'(0));
    expect_eq("arst_data", 128'({m0_resp_a, s_req_a}), 128'(0));
    @(negedge clk);
    rstn = 1'b1; m0_resp_ready = 1'b1;
    m1_req = '{32'h600, 32'h99, 4'h7, 1'b1}; m1_req_valid = 1'b1;
    @(negedge clk); #1;
    exp_r = '{32'h600, 32'h99, 4'h7, 1'b1};
    expect_eq("post_rst_grant", 128'(grant_id_a), 128'(1));
    expect_eq("post_rst_s_req", 128'({s_req_valid_a, s_req_a}), 128'({1'b1, exp_r}));
    expect_eq("post_rst_no_m0", 128'(m0_resp_valid_a), 128'(0));
    @(negedge clk); m1_req_valid = 1'b0; #1;
    expect_eq("post_rst_resp", 128'({m1_resp_valid_a, m1_resp_a}), 128'({1'b1, 32'h9A, 1'b1}));
    @(negedge clk); #1;
    expect_eq("post_rst_idle", 128'(s_resp_ready_a), 128'(0));

    // m0 completes (last_grant=0), then granted m1 withdraws; next tie goes to m1
    m0_req = '{32'h700, 32'h11, 4'hF, 1'b1}; m0_req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); m0_req_valid = 1'b0;
    @(negedge clk);
    s_rdy = 1'b0; m1_req_valid = 1'b1; hs0 = ga.size();
    @(negedge clk); #1;
    expect_eq("ab_grant", 128'({grant_id_a, s_req_valid_a}), 128'(2'b11));
    @(negedge clk); m1_req_valid = 1'b0; #1;
    expect_eq("ab_s_req_zero", 128'({s_req_valid_a, s_req_a, m1_req_ready_a}), 128'(0));
    @(negedge clk); #1;
    expect_eq("ab_no_handshake", 128'(ga.size() - hs0), 128'(0));
    s_rdy = 1'b1; m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    @(negedge clk); #1;
    expect_eq("ab_tie_grants_m1", 128'({grant_id_a, s_req_valid_a}), 128'(2'b11));
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
